// File: rtl/run_seq_pkg.sv
// Shared types and default sizing for the run sequencer and its timer.
package run_seq_pkg;

    localparam int unsigned AW_DEF      = 8;
    localparam int unsigned DW_DEF      = 8;
    localparam int unsigned CW_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRESET,
        ST_RUN,
        ST_READ,
        ST_FIN
    } state_t;

endpackage

// File: rtl/run_timer.sv
// RUN-phase cycle counter with saturating timeout detect and result latch.
module run_timer
    import run_seq_pkg::*;
#(
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          run,
    input  logic          proc_done,
    output logic [CW-1:0] count,
    output logic          done_c,
    output logic          expire_c,
    output logic [CW-1:0] cycles,
    output logic          timed_out
);

    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    // Completion beats timeout when both land in the same cycle
    always_comb begin
        done_c   = run && proc_done;
        expire_c = run && !proc_done && (count >= LAST);
    end

    // Counter restarts at zero on every entry to RUN
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else if (count < LAST) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cycles    <= '0;
            timed_out <= 1'b0;
        end else if (done_c) begin
            cycles <= count + CW'(1);
        end else if (expire_c) begin
            cycles    <= LIMIT;
            timed_out <= 1'b1;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Job sequencer: preload data memory, reset and run the processor,
// then stream a window of memory back out.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_count,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_last,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_host_sel,
    output logic          proc_reset,
    output logic          proc_req,
    input  logic          proc_done,
    output logic          rb_valid,
    input  logic          rb_ready,
    output logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycles
);

    state_t        state;
    state_t        state_nxt;
    logic          preset_cnt;
    logic [AW-1:0] rd_base_q;
    logic [AW:0]   rd_count_q;
    logic [AW:0]   idx;
    logic [CW-1:0] run_count;
    logic          done_c;
    logic          expire_c;
    logic          start_acc_c;
    logic          ld_acc_c;
    logic          rd_empty_c;
    logic          rb_xfer_c;
    logic          rb_last_c;
    logic [AW-1:0] rd_addr_c;

    always_comb begin
        start_acc_c = (state == ST_IDLE) && start;
        ld_acc_c    = (state == ST_LOAD) && ld_valid;
        rd_empty_c  = (rd_count_q == '0);
        rb_xfer_c   = (state == ST_READ) && !rd_empty_c && rb_ready;
        rb_last_c   = (idx == rd_count_q - (AW+1)'(1));
        rd_addr_c   = rd_base_q + idx[AW-1:0];
    end

    run_timer #(
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (start_acc_c),
        .run       (state == ST_RUN),
        .proc_done (proc_done),
        .count     (run_count),
        .done_c    (done_c),
        .expire_c  (expire_c),
        .cycles    (cycles),
        .timed_out (timed_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_LOAD;
            ST_LOAD:   if (ld_valid && ld_last) state_nxt = ST_PRESET;
            ST_PRESET: if (preset_cnt) state_nxt = ST_RUN;
            ST_RUN: begin
                if (done_c) begin
                    state_nxt = ST_READ;
                end else if (expire_c) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_READ: begin
                if (rd_empty_c || (rb_xfer_c && rb_last_c)) begin
                    state_nxt = ST_FIN;
                end
            end
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state; reset silences everything except proc_reset
    always_comb begin
        ld_ready     = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_host_sel = 1'b0;
        proc_reset   = reset;
        proc_req     = 1'b0;
        rb_valid     = 1'b0;
        rb_addr      = '0;
        rb_data      = '0;
        busy         = 1'b0;
        finished     = 1'b0;
        if (!reset) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_LOAD: begin
                    ld_ready     = 1'b1;
                    mem_host_sel = 1'b1;
                    if (ld_acc_c) begin
                        mem_we    = 1'b1;
                        mem_addr  = ld_addr;
                        mem_wdata = ld_data;
                    end
                end
                ST_PRESET: proc_reset = 1'b1;
                ST_RUN:    proc_req   = (run_count == '0);
                ST_READ: begin
                    mem_host_sel = 1'b1;
                    if (!rd_empty_c) begin
                        rb_valid = 1'b1;
                        mem_addr = rd_addr_c;
                        rb_addr  = rd_addr_c;
                        rb_data  = mem_rdata;
                    end
                end
                ST_FIN:    finished = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            preset_cnt <= 1'b0;
            rd_base_q  <= '0;
            rd_count_q <= '0;
            idx        <= '0;
        end else begin
            if (start_acc_c) begin
                rd_base_q  <= rd_base;
                rd_count_q <= rd_count;
                idx        <= '0;
            end
            if (state == ST_PRESET) begin
                preset_cnt <= !preset_cnt;
            end else begin
                preset_cnt <= 1'b0;
            end
            if (rb_xfer_c) begin
                idx <= idx + (AW+1)'(1);
            end
        end
    end

endmodule
